seg7_display_reader: RTL and testbench



---
 rtl/seg7_display_reader_pkg.sv | 13 +
 rtl/seg7_display_reader_if.sv | 12 +
 rtl/seg7_codes.vh | 32 +++
 rtl/seg7_pattern_encoder.sv | 37 +++
 rtl/seg7_display_reader.sv | 108 ++++++++++
 tb/tb_seg7_display_reader.sv | 163 ++++++++++++++++
 6 files changed

// File: rtl/seg7_display_reader_pkg.sv
// Shared types and helpers for the 7-segment display reader.
package seg7_display_reader_pkg;

  localparam int MAX_DIGITS = 8;

  typedef logic [3:0] nibble_t;
  typedef logic [3:0] cnt_t;

  function automatic logic onehot8(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

endpackage

// File: rtl/seg7_display_reader_if.sv
// Display bus snooped by the reader plus the recovered-value outputs.
interface seg7_display_reader_if #(parameter int DIGITS = 4);
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] value;
  logic                valid;
  logic                locked;
  logic                bad_pattern;

  modport master (output seg, dig_sel, input value, valid, locked, bad_pattern);
  modport slave  (input seg, dig_sel, output value, valid, locked, bad_pattern);
endinterface

// File: rtl/seg7_codes.vh
// Shared 7-segment glyph codes and segment bit positions (bit0=a .. bit6=g, bit7=h).
// Used by both the display decoder and the display reader so the table lives in one place.
`ifndef SEG7_CODES_VH
`define SEG7_CODES_VH

`define SEG7_BIT_A 0
`define SEG7_BIT_B 1
`define SEG7_BIT_C 2
`define SEG7_BIT_D 3
`define SEG7_BIT_E 4
`define SEG7_BIT_F 5
`define SEG7_BIT_G 6
`define SEG7_BIT_H 7

`define SEG7_GLYPH_0 7'h3F
`define SEG7_GLYPH_1 7'h06
`define SEG7_GLYPH_2 7'h5B
`define SEG7_GLYPH_3 7'h4F
`define SEG7_GLYPH_4 7'h66
`define SEG7_GLYPH_5 7'h6D
`define SEG7_GLYPH_6 7'h7D
`define SEG7_GLYPH_7 7'h07
`define SEG7_GLYPH_8 7'h7F
`define SEG7_GLYPH_9 7'h6F
`define SEG7_GLYPH_A 7'h77
`define SEG7_GLYPH_B 7'h7C
`define SEG7_GLYPH_C 7'h39
`define SEG7_GLYPH_D 7'h5E
`define SEG7_GLYPH_E 7'h79
`define SEG7_GLYPH_F 7'h71

`endif

// File: rtl/seg7_pattern_encoder.sv
// Combinational inverse of the 7-segment glyph table: pattern -> nibble plus a legal-glyph flag.
`include "seg7_codes.vh"

module seg7_pattern_encoder (
  input  logic [6:0] in_i,
  output logic [3:0] out_o,
  output logic       hit_o
);

  always_comb begin
    out_o = 4'h0;
    hit_o = 1'b1;
    case (in_i)
      `SEG7_GLYPH_0: out_o = 4'h0;
      `SEG7_GLYPH_1: out_o = 4'h1;
      `SEG7_GLYPH_2: out_o = 4'h2;
      `SEG7_GLYPH_3: out_o = 4'h3;
      `SEG7_GLYPH_4: out_o = 4'h4;
      `SEG7_GLYPH_5: out_o = 4'h5;
      `SEG7_GLYPH_6: out_o = 4'h6;
      `SEG7_GLYPH_7: out_o = 4'h7;
      `SEG7_GLYPH_8: out_o = 4'h8;
      `SEG7_GLYPH_9: out_o = 4'h9;
      `SEG7_GLYPH_A: out_o = 4'hA;
      `SEG7_GLYPH_B: out_o = 4'hB;
      `SEG7_GLYPH_C: out_o = 4'hC;
      `SEG7_GLYPH_D: out_o = 4'hD;
      `SEG7_GLYPH_E: out_o = 4'hE;
      `SEG7_GLYPH_F: out_o = 4'hF;
      default: begin
        out_o = 4'h0;
        hit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_display_reader.sv
// Snoops a multiplexed 7-segment bus, qualifies each digit over several scans and
// publishes the displayed hex word once every digit is stable.
module seg7_display_reader
  import seg7_display_reader_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int STABLE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_display_reader_if.slave  bus
);

  localparam cnt_t STABLE_CNT = cnt_t'(STABLE_SCANS);

  logic [6:0]          s1_seg_q, s2_seg_q;
  logic [DIGITS-1:0]   s1_sel_q, s2_sel_q;
  nibble_t             cap_q [DIGITS];
  nibble_t             cap_d [DIGITS];
  cnt_t                cnt_q [DIGITS];
  cnt_t                cnt_d [DIGITS];
  logic [4*DIGITS-1:0] value_q, word_s;
  logic                valid_q, locked_q, bad_q, published_q;
  logic                sample_s, hit_s, all_stable_s, publish_s;
  nibble_t             glyph_s;

  // The last cycle of a dwell: a single digit is on and the select is about to change.
  assign sample_s = onehot8(8'(s2_sel_q)) && (s1_sel_q != s2_sel_q);

  seg7_pattern_encoder u_enc (
    .in_i  (s2_seg_q),
    .out_o (glyph_s),
    .hit_o (hit_s)
  );

  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      cap_d[i] = cap_q[i];
      cnt_d[i] = cnt_q[i];
      if (sample_s && s2_sel_q[i]) begin
        if (!hit_s) begin
          cnt_d[i] = 4'd0;
        end else if (glyph_s == cap_q[i]) begin
          cnt_d[i] = (cnt_q[i] < STABLE_CNT) ? cnt_q[i] + 4'd1 : STABLE_CNT;
        end else begin
          cap_d[i] = glyph_s;
          cnt_d[i] = 4'd1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    all_stable_s = 1'b1;
    word_s       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      word_s[4*i +: 4] = cap_q[i];
      if (cnt_q[i] != STABLE_CNT) begin
        all_stable_s = 1'b0;
      end else begin
        all_stable_s = all_stable_s;
      end
    end
  end

  // First publish after reset is forced even when the word equals the reset value.
  assign publish_s = all_stable_s && ((word_s != value_q) || !published_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_seg_q    <= 7'h00;
      s2_seg_q    <= 7'h00;
      s1_sel_q    <= '0;
      s2_sel_q    <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      bad_q       <= 1'b0;
      published_q <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        cap_q[i] <= 4'd0;
        cnt_q[i] <= 4'd0;
      end
    end else begin
      s1_seg_q    <= bus.seg[6:0];
      s2_seg_q    <= s1_seg_q;
      s1_sel_q    <= bus.dig_sel;
      s2_sel_q    <= s1_sel_q;
      locked_q    <= all_stable_s;
      valid_q     <= publish_s;
      value_q     <= publish_s ? word_s : value_q;
      published_q <= published_q | publish_s;
      bad_q       <= sample_s && !hit_s;
      for (int i = 0; i < DIGITS; i++) begin
        cap_q[i] <= cap_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.valid       = valid_q;
  assign bus.locked      = locked_q;
  assign bus.bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_display_reader.sv
// Directed bench for seg7_display_reader: table of scan phases plus reset and latency sequences.
module tb_seg7_display_reader;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vcnt_a   = 0;
  int   bcnt_a   = 0;

  always #5 clk = ~clk;

  seg7_display_reader_if #(.DIGITS(4)) ifa ();
  seg7_display_reader_if #(.DIGITS(4)) ifb ();

  seg7_display_reader #(.DIGITS(4), .STABLE_SCANS(3)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  seg7_display_reader #(.DIGITS(4), .STABLE_SCANS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  typedef struct {
    logic [31:0] pats;     // {d3,d2,d1,d0} segment bytes
    int          scans;
    int          dwell;
    bit          gap;
    logic [15:0] exp_value;
    int          exp_valid;
    logic        exp_locked;
    int          exp_bad;
  } vec_t;

  vec_t vecs [9];

  always @(negedge clk) begin
    if (ifa.valid) vcnt_a++;
    if (ifa.bad_pattern) bcnt_a++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic scan_a(input logic [31:0] pats, input int dwell, input bit gap);
    for (int d = 0; d < 4; d++) begin
      ifa.dig_sel = 4'(1 << d);
      ifa.seg     = pats[8*d +: 8];
      repeat (dwell) step();
      if (gap) begin
        ifa.dig_sel = 4'b0011;
        ifa.seg     = 8'h00;
        step();
        ifa.dig_sel = 4'b0000;
        step();
      end
    end
  endtask

  task automatic flush_a();
    ifa.dig_sel = 4'b0000;
    ifa.seg     = 8'h00;
    repeat (6) step();
  endtask

  initial begin
    vecs[0] = '{32'h06775B71, 3, 5, 1'b0, 16'h1A2F, 1, 1'b1, 0};
    vecs[1] = '{32'h06775B71, 3, 1, 1'b0, 16'h1A2F, 0, 1'b1, 0};
    vecs[2] = '{32'h06775B39, 1, 5, 1'b0, 16'h1A2F, 0, 1'b0, 0};
    vecs[3] = '{32'h06775B39, 2, 5, 1'b0, 16'h1A2C, 1, 1'b1, 0};
    vecs[4] = '{32'h06005B39, 1, 5, 1'b0, 16'h1A2C, 0, 1'b0, 1};
    vecs[5] = '{32'h06775B39, 2, 2, 1'b0, 16'h1A2C, 0, 1'b0, 0};
    vecs[6] = '{32'h06775B39, 1, 5, 1'b0, 16'h1A2C, 0, 1'b1, 0};
    vecs[7] = '{32'h7F077D6D, 2, 3, 1'b1, 16'h1A2C, 0, 1'b0, 0};
    vecs[8] = '{32'h7F077D6D, 1, 3, 1'b1, 16'h8765, 1, 1'b1, 0};

    reset = 1'b1;
    ifa.seg = 8'h00; ifa.dig_sel = 4'b0000;
    ifb.seg = 8'h00; ifb.dig_sel = 4'b0000;
    repeat (3) step();
    chk("reset_value",  32'(ifa.value), 32'h0);
    chk("reset_valid",  32'(ifa.valid), 32'h0);
    chk("reset_locked", 32'(ifa.locked), 32'h0);
    chk("reset_bad",    32'(ifa.bad_pattern), 32'h0);
    reset = 1'b0;
    step();

    for (int r = 0; r < 9; r++) begin
      vcnt_a = 0;
      bcnt_a = 0;
      for (int s = 0; s < vecs[r].scans; s++) scan_a(vecs[r].pats, vecs[r].dwell, vecs[r].gap);
      flush_a();
      chk($sformatf("row%0d_value", r),  32'(ifa.value), 32'(vecs[r].exp_value));
      chk($sformatf("row%0d_valid", r),  32'(vcnt_a), 32'(vecs[r].exp_valid));
      chk($sformatf("row%0d_locked", r), 32'(ifa.locked), 32'(vecs[r].exp_locked));
      chk($sformatf("row%0d_bad", r),    32'(bcnt_a), 32'(vecs[r].exp_bad));
    end

    // Asynchronous reset mid-dwell while locked on 0x8765.
    ifa.dig_sel = 4'b0010;
    ifa.seg     = 8'h7D;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_value",  32'(ifa.value), 32'h0);
    chk("async_locked", 32'(ifa.locked), 32'h0);
    chk("async_valid",  32'(ifa.valid), 32'h0);
    ifa.dig_sel = 4'b0000;
    ifa.seg     = 8'h00;
    step();
    step();
    reset = 1'b0;
    vcnt_a = 0;
    bcnt_a = 0;
    for (int s = 0; s < 3; s++) scan_a(32'h3F3F3F3F, 5, 1'b0);
    flush_a();
    chk("zero_valid",  32'(vcnt_a), 32'd1);
    chk("zero_value",  32'(ifa.value), 32'h0);
    chk("zero_locked", 32'(ifa.locked), 32'h1);

    // STABLE_SCANS=1 with 1-cycle dwells and the decimal point lit on every digit.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    ifb.dig_sel = 4'b0001; ifb.seg = 8'h86; step();
    ifb.dig_sel = 4'b0010; ifb.seg = 8'hDB; step();
    ifb.dig_sel = 4'b0100; ifb.seg = 8'hCF; step();
    ifb.dig_sel = 4'b1000; ifb.seg = 8'hE6; step();
    ifb.dig_sel = 4'b0000; ifb.seg = 8'h00;
    step();
    step();
    chk("lat2_valid",  32'(ifb.valid), 32'h0);
    chk("lat2_locked", 32'(ifb.locked), 32'h0);
    step();
    chk("lat3_valid",  32'(ifb.valid), 32'h1);
    chk("lat3_value",  32'(ifb.value), 32'h4321);
    chk("lat3_locked", 32'(ifb.locked), 32'h1);
    step();
    chk("lat4_valid",  32'(ifb.valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
